// File: rtl/spi_frame_ctrl_if.sv
// Command handshake bundle between spi_frame_ctrl (master) and game logic (slave).
interface spi_frame_ctrl_if #(
  parameter int FRAME_BYTES = 3
) ();
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [7:0]                   cmd_op;
  logic [8*(FRAME_BYTES-1)-1:0] cmd_arg;
  logic                         frame_err;

  modport master (output cmd_valid, cmd_op, cmd_arg, frame_err, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, frame_err, output cmd_ready);
endinterface

// File: rtl/spi_frame_ctrl.sv
// Oversampled SPI receiver that assembles fixed-length command frames for game logic.
// Optional status readback on sdo is enabled by defining SPI_FRAME_STATUS_EN.
//
// state   | meaning
// IDLE    | ce low, waiting for ce_rise
// RECV    | ce high, shifting bits into the frame buffer
// OVERRUN | more bytes than FRAME_BYTES arrived; wait for ce_fall
module spi_frame_ctrl #(
  parameter int FRAME_BYTES = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic sdi,
  input  logic ce,
  output logic sdo,
  output logic busy,
  spi_frame_ctrl_if.master cmd
);

  localparam int FW = 8 * FRAME_BYTES;
  localparam int AW = 8 * (FRAME_BYTES - 1);
  localparam logic [3:0] FB = 4'(FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, RECV, OVERRUN} state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES:0]   sck_sh, ce_sh;
  logic [SYNC_STAGES-1:0] sdi_sh;
  logic sck_rise, ce_rise, ce_fall, sdi_s;

  logic [2:0]    bit_cnt, bit_nx;
  logic [3:0]    byte_cnt, byte_nx;
  logic [6:0]    shift, shift_nx;
  logic [7:0]    byte_new;
  logic [FW-1:0] fbuf, fbuf_nx;
  logic          load, err, drop, ovr;

  logic          cmd_valid;
  logic [7:0]    cmd_op;
  logic [AW-1:0] cmd_arg;
  logic          frame_err;

  assign sck_rise = sck_sh[SYNC_STAGES-1] & ~sck_sh[SYNC_STAGES];
  assign ce_rise  = ce_sh[SYNC_STAGES-1] & ~ce_sh[SYNC_STAGES];
  assign ce_fall  = ~ce_sh[SYNC_STAGES-1] & ce_sh[SYNC_STAGES];
  assign sdi_s    = sdi_sh[SYNC_STAGES-1];
  assign byte_new = {shift, sdi_s};
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    bit_nx   = bit_cnt;
    byte_nx  = byte_cnt;
    shift_nx = shift;
    fbuf_nx  = fbuf;
    load     = 1'b0;
    err      = 1'b0;
    drop     = 1'b0;
    ovr      = 1'b0;
    case (state)
      IDLE: begin
        if (ce_rise) begin
          bit_nx   = 3'd0;
          byte_nx  = 4'd0;
          state_nx = RECV;
        end
      end
      RECV: begin
        if (sck_rise) begin
          shift_nx = byte_new[6:0];
          bit_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (byte_cnt == FB) begin
              state_nx = OVERRUN;
              ovr      = 1'b1;
            end else begin
              for (int i = 0; i < FRAME_BYTES; i++)
                if (byte_cnt == 4'(i)) fbuf_nx[8*(FRAME_BYTES-1-i) +: 8] = byte_new;
              byte_nx = byte_cnt + 4'd1;
            end
          end
        end
        // A bit arriving in the ce_fall cycle is counted before the frame is judged.
        if (ce_fall) begin
          state_nx = IDLE;
          if (!ovr && byte_nx == FB && bit_nx == 3'd0) begin
            if (!cmd_valid || cmd.cmd_ready) begin
              load = 1'b1;
            end else begin
              err  = 1'b1;
              drop = 1'b1;
            end
          end else begin
            err = 1'b1;
          end
        end
      end
      OVERRUN: begin
        if (ce_fall) begin
          err      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_sh    <= '0;
      ce_sh     <= '0;
      sdi_sh    <= '0;
      state     <= IDLE;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      fbuf      <= '0;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_arg   <= '0;
      frame_err <= 1'b0;
    end else begin
      sck_sh    <= {sck_sh[SYNC_STAGES-1:0], sck};
      ce_sh     <= {ce_sh[SYNC_STAGES-1:0], ce};
      sdi_sh    <= {sdi_sh[SYNC_STAGES-2:0], sdi};
      state     <= state_nx;
      bit_cnt   <= bit_nx;
      byte_cnt  <= byte_nx;
      shift     <= shift_nx;
      fbuf      <= fbuf_nx;
      frame_err <= err;
      if (load) begin
        cmd_valid <= 1'b1;
        cmd_op    <= fbuf_nx[FW-1 -: 8];
        cmd_arg   <= fbuf_nx[AW-1:0];
      end else if (cmd_valid && cmd.cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  assign cmd.cmd_valid = cmd_valid;
  assign cmd.cmd_op    = cmd_op;
  assign cmd.cmd_arg   = cmd_arg;
  assign cmd.frame_err = frame_err;

`ifdef SPI_FRAME_STATUS_EN
  logic       rx_drop_seen, overrun_seen;
  logic [2:0] err_cnt;
  logic [7:0] stat_sh;
  logic       sck_fall;

  assign sck_fall = ~sck_sh[SYNC_STAGES-1] & sck_sh[SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_drop_seen <= 1'b0;
      overrun_seen <= 1'b0;
      err_cnt      <= '0;
      stat_sh      <= '0;
    end else begin
      if (drop) rx_drop_seen <= 1'b1;
      if (ovr)  overrun_seen <= 1'b1;
      if (err && err_cnt != 3'd7) err_cnt <= err_cnt + 3'd1;
      if (state == IDLE && ce_rise)
        stat_sh <= {cmd_valid, rx_drop_seen, overrun_seen, 2'b00, err_cnt};
      else if (sck_fall)
        stat_sh <= {stat_sh[6:0], 1'b0};
    end
  end

  assign sdo = busy & stat_sh[7];
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Directed self-checking bench for spi_frame_ctrl with FRAME_BYTES=3, SYNC_STAGES=2.
module tb_spi_frame_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic ce = 1'b0;
  logic sdo, busy;

  int errors = 0;
  int checks = 0;
  int ferr_seen = 0;
  int vcyc = 0;

  spi_frame_ctrl_if #(.FRAME_BYTES(3)) cif ();

  spi_frame_ctrl #(.FRAME_BYTES(3), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .sck   (sck),
    .sdi   (sdi),
    .ce    (ce),
    .sdo   (sdo),
    .busy  (busy),
    .cmd   (cif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cif.frame_err) ferr_seen++;
    if (cif.cmd_valid) vcyc++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // MSB first; sdo is captured just before each sck rise, as a mode-0 master would.
  task automatic send_bits(input logic [63:0] d, input int n, output logic [63:0] so);
    so = '0;
    for (int i = 0; i < n; i++) begin
      sdi = d[n-1-i];
      tick(4);
      so = {so[62:0], sdo};
      sck = 1'b1;
      tick(4);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [63:0] d, input int n, output logic [63:0] so);
    ce = 1'b1;
    tick(4);
    send_bits(d, n, so);
    tick(4);
    ce = 1'b0;
    tick(8);
  endtask

  initial begin
    int f0, v0;
    logic [63:0] so;
    cif.cmd_ready = 1'b1;
    tick(3);
    chk("rst_valid", 64'(cif.cmd_valid), 64'd0);
    chk("rst_op",    64'(cif.cmd_op), 64'd0);
    chk("rst_arg",   64'(cif.cmd_arg), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_sdo",   64'(sdo), 64'd0);
    reset = 1'b1;
    tick(2);

    // good frame with consumer ready
    f0 = ferr_seen; v0 = vcyc;
    frame(64'h123456, 24, so);
    chk("t1_valid_cycles", 64'(vcyc - v0), 64'd1);
    chk("t1_op",  64'(cif.cmd_op), 64'h12);
    chk("t1_arg", 64'(cif.cmd_arg), 64'h3456);
    chk("t1_ferr", 64'(ferr_seen - f0), 64'd0);
    chk("t1_sdo", so, 64'd0);

    // 12-bit runt frame, then a good frame
    f0 = ferr_seen; v0 = vcyc;
    frame(64'hABC, 12, so);
    chk("t2_ferr", 64'(ferr_seen - f0), 64'd1);
    chk("t2_valid_cycles", 64'(vcyc - v0), 64'd0);
    frame(64'hA00102, 24, so);
    chk("t2_op",  64'(cif.cmd_op), 64'hA0);
    chk("t2_arg", 64'(cif.cmd_arg), 64'h0102);

    // held frame A, frame B dropped
    cif.cmd_ready = 1'b0;
    f0 = ferr_seen;
    frame(64'h112233, 24, so);
    chk("t3_valid_a", 64'(cif.cmd_valid), 64'd1);
    chk("t3_ferr_a", 64'(ferr_seen - f0), 64'd0);
    frame(64'h445566, 24, so);
    chk("t3_ferr_b", 64'(ferr_seen - f0), 64'd1);
    chk("t3_op_held",  64'(cif.cmd_op), 64'h11);
    chk("t3_arg_held", 64'(cif.cmd_arg), 64'h2233);
    chk("t3_valid_held", 64'(cif.cmd_valid), 64'd1);
    cif.cmd_ready = 1'b1;
    tick(1);
    chk("t3_valid_clear", 64'(cif.cmd_valid), 64'd0);
    tick(2);

    // status readback window (one byte, so it also counts as a bad frame)
    f0 = ferr_seen;
    frame(64'h00, 8, so);
`ifdef SPI_FRAME_STATUS_EN
    chk("st_sdo", so, 64'h42);
`else
    chk("st_sdo", so, 64'h00);
`endif
    chk("st_ferr", 64'(ferr_seen - f0), 64'd1);

    // overrun: four bytes in one ce window
    f0 = ferr_seen; v0 = vcyc;
    ce = 1'b1;
    tick(4);
    send_bits(64'hDEADBEEF, 32, so);
    tick(4);
    chk("ov_busy", 64'(busy), 64'd1);
    ce = 1'b0;
    tick(8);
    chk("ov_ferr", 64'(ferr_seen - f0), 64'd1);
    chk("ov_valid_cycles", 64'(vcyc - v0), 64'd0);
    chk("ov_idle", 64'(busy), 64'd0);

    // reset in the middle of a frame
    chk("rs_op_before", 64'(cif.cmd_op), 64'h11);
    f0 = ferr_seen;
    ce = 1'b1;
    tick(4);
    send_bits(64'h3FF, 10, so);
    chk("rs_busy_before", 64'(busy), 64'd1);
    ce = 1'b0;
    reset = 1'b0;
    tick(1);
    chk("rs_valid", 64'(cif.cmd_valid), 64'd0);
    chk("rs_op",    64'(cif.cmd_op), 64'd0);
    chk("rs_arg",   64'(cif.cmd_arg), 64'd0);
    chk("rs_busy",  64'(busy), 64'd0);
    chk("rs_sdo",   64'(sdo), 64'd0);
    chk("rs_ferr_now", 64'(cif.frame_err), 64'd0);
    reset = 1'b1;
    tick(10);
    chk("rs_ferr", 64'(ferr_seen - f0), 64'd0);
    frame(64'h010203, 24, so);
    chk("rs_op_after",  64'(cif.cmd_op), 64'h01);
    chk("rs_arg_after", 64'(cif.cmd_arg), 64'h0203);
    chk("rs_ferr_after", 64'(ferr_seen - f0), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
